// File: rtl/fir_coeff_loader.sv
// FIR coefficient writer: host fills a shadow bank, which is copied to the active bank
// on a sample-strobe boundary. Also generates the sample strobe and active-bank readback.
module fir_coeff_loader #(
  parameter int NUM_TAPS   = 10,
  parameter int COEFF_W    = 16,
  parameter int ADDR_W     = 4,
  parameter int SAMPLE_DIV = 40
) (
  input  logic                          iClk_12M,
  input  logic                          iRsn,
  input  logic                          iCoeffUpdateFlag,
  input  logic                          iWrEn,
  input  logic [ADDR_W-1:0]             iAddr,
  input  logic [COEFF_W-1:0]            iWrDt,
  input  logic                          iRdEn,
  output logic [COEFF_W-1:0]            oRdDt,
  output logic                          oRdValid,
  output logic                          oEnSample_300k,
  output logic [NUM_TAPS*COEFF_W-1:0]   oCoeffBus,
  output logic                          oBusy,
  output logic                          oCommitDone,
  output logic                          oAddrErr
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PEND} state_t;

  state_t                      state_reg;
  logic [CNT_W-1:0]            cnt_reg;
  logic [COEFF_W-1:0]          shadow_reg [NUM_TAPS];
  logic [COEFF_W-1:0]          active_reg [NUM_TAPS];
  logic [COEFF_W-1:0]          rd_dt_reg;
  logic                        rd_valid_reg;
  logic                        addr_err_reg;
  logic [COEFF_W-1:0]          rd_mux;
  logic [NUM_TAPS*COEFF_W-1:0] coeff_bus;
  logic                        cnt_last;
  logic                        strobe;
  logic                        commit;
  logic                        addr_ok;
  logic                        wr_fire;

  assign cnt_last = (cnt_reg == CNT_LAST);
  assign strobe   = !iRsn && cnt_last;
  assign addr_ok  = (32'(iAddr) < NUM_TAPS);
  assign wr_fire  = iCoeffUpdateFlag && iWrEn;
  // The flag wins over a coincident strobe, so a reopened session cancels the commit.
  assign commit   = (state_reg == PEND) && !iCoeffUpdateFlag && strobe;

  always_ff @(posedge iClk_12M) begin
    if (iRsn) begin
      cnt_reg <= '0;
    end else if (cnt_last) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge iClk_12M) begin
    if (iRsn) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (iCoeffUpdateFlag) state_reg <= LOAD;
        LOAD:    if (!iCoeffUpdateFlag) state_reg <= PEND;
        PEND: begin
          if (iCoeffUpdateFlag) state_reg <= LOAD;
          else if (strobe)      state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
      always_ff @(posedge iClk_12M) begin
        if (iRsn) begin
          shadow_reg[gi] <= '0;
        end else if (wr_fire && (32'(iAddr) == gi)) begin
          shadow_reg[gi] <= iWrDt;
        end
      end

      always_ff @(posedge iClk_12M) begin
        if (iRsn) begin
          active_reg[gi] <= '0;
        end else if (commit) begin
          active_reg[gi] <= shadow_reg[gi];
        end
      end

      assign coeff_bus[gi*COEFF_W +: COEFF_W] = active_reg[gi];
    end
  endgenerate

  // Out-of-range addresses match no tap and so read back as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (32'(iAddr) == i) rd_mux = active_reg[i];
    end
  end

  always_ff @(posedge iClk_12M) begin
    if (iRsn) begin
      rd_valid_reg <= 1'b0;
      rd_dt_reg    <= '0;
    end else begin
      rd_valid_reg <= iRdEn;
      if (iRdEn) rd_dt_reg <= rd_mux;
    end
  end

  always_ff @(posedge iClk_12M) begin
    if (iRsn) begin
      addr_err_reg <= 1'b0;
    end else if (wr_fire && !addr_ok) begin
      addr_err_reg <= 1'b1;
    end
  end

  // Reset forces every output low in the same cycle it is asserted.
  assign oEnSample_300k = strobe;
  assign oCommitDone    = !iRsn && commit;
  assign oBusy          = !iRsn && (state_reg != IDLE);
  assign oCoeffBus      = iRsn ? '0 : coeff_bus;
  assign oRdDt          = iRsn ? '0 : rd_dt_reg;
  assign oRdValid       = !iRsn && rd_valid_reg;
  assign oAddrErr       = !iRsn && addr_err_reg;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Bench for fir_coeff_loader: table vectors, directed session sequences and random
// traffic, all checked every cycle against a behavioural model of the coefficient banks.
module tb_fir_coeff_loader;

  localparam int NT  = 10;
  localparam int CW  = 16;
  localparam int AW  = 4;
  localparam int DIV = 40;
  localparam int BW  = NT * CW;

  logic          clk = 1'b0;
  logic          rst, flag, we, re;
  logic [AW-1:0] addr;
  logic [CW-1:0] wdt;
  logic [CW-1:0] rd_dt;
  logic          rd_valid, strobe, busy, commit, addr_err;
  logic [BW-1:0] bus;

  always #5 clk = ~clk;

  fir_coeff_loader #(.NUM_TAPS(NT), .COEFF_W(CW), .ADDR_W(AW), .SAMPLE_DIV(DIV)) dut (
    .iClk_12M(clk), .iRsn(rst), .iCoeffUpdateFlag(flag), .iWrEn(we), .iAddr(addr),
    .iWrDt(wdt), .iRdEn(re), .oRdDt(rd_dt), .oRdValid(rd_valid), .oEnSample_300k(strobe),
    .oCoeffBus(bus), .oBusy(busy), .oCommitDone(commit), .oAddrErr(addr_err)
  );

  int checks = 0;
  int failures = 0;

  // Model: cycles since reset release, both banks, session/pending status, readback.
  int            m_n;
  logic [CW-1:0] m_sh [NT];
  logic [CW-1:0] m_ac [NT];
  logic [CW-1:0] m_rd;
  bit            m_prev_flag, m_owed, m_err, m_rdv;
  int            n_commits = 0;

  bit            o_strobe, o_commit, o_busy, o_rdv, o_err;
  logic [CW-1:0] o_rd;
  logic [BW-1:0] o_bus;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_cycle(input bit r, input bit f, input bit w, input int a,
                          input logic [CW-1:0] d, input bit rd);
    bit            s_e, c_e, b_e;
    logic [BW-1:0] bus_e;
    rst = r; flag = f; we = w; addr = a[AW-1:0]; wdt = d; re = rd;
    @(negedge clk);
    o_strobe = strobe; o_commit = commit; o_busy = busy; o_rdv = rd_valid;
    o_err = addr_err; o_rd = rd_dt; o_bus = bus;
    if (o_commit) n_commits++;
    bus_e = '0;
    s_e = 1'b0; c_e = 1'b0; b_e = 1'b0;
    if (!r) begin
      s_e = ((m_n % DIV) == DIV - 1);
      c_e = m_owed && !f && s_e;
      b_e = m_prev_flag || m_owed;
      for (int k = 0; k < NT; k++) bus_e[k*CW +: CW] = m_ac[k];
    end
    check("strobe", BW'(o_strobe), BW'(s_e));
    check("commit_done", BW'(o_commit), BW'(c_e));
    check("busy", BW'(o_busy), BW'(b_e));
    check("coeff_bus", o_bus, bus_e);
    check("rd_valid", BW'(o_rdv), BW'(r ? 1'b0 : m_rdv));
    check("rd_dt", BW'(o_rd), BW'(r ? '0 : m_rd));
    check("addr_err", BW'(o_err), BW'(r ? 1'b0 : m_err));
    @(posedge clk);
    #1;
    if (r) begin
      m_n = 0; m_rd = '0; m_rdv = 0; m_err = 0; m_owed = 0; m_prev_flag = 0;
      for (int k = 0; k < NT; k++) begin m_sh[k] = '0; m_ac[k] = '0; end
    end else begin
      if (rd) m_rd = (a < NT) ? m_ac[a] : '0;
      m_rdv = rd;
      if (c_e) m_ac = m_sh;
      if (f && w) begin
        if (a < NT) m_sh[a] = d;
        else        m_err = 1;
      end
      m_owed = !f && (m_prev_flag || (m_owed && !s_e));
      m_prev_flag = f;
      m_n++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, '0, 0);
  endtask

  typedef struct {
    bit r, f, w; int a; logic [CW-1:0] d; bit rd;
    bit busy_e, err_e, rdv_e; logic [CW-1:0] rddt_e;
  } vec_t;

  vec_t          tbl [7];
  logic [BW-1:0] exp1, exp2;
  int            nst, pos, cbase, found;
  bit            fl;

  initial begin
    tbl[0] = '{1, 0, 0,  0, 16'h0000, 0, 0, 0, 0, 16'h0000};
    tbl[1] = '{0, 1, 1,  0, 16'h1234, 0, 0, 0, 0, 16'h0000};
    tbl[2] = '{0, 1, 1, 12, 16'h5555, 0, 1, 0, 0, 16'h0000};
    tbl[3] = '{0, 1, 0,  0, 16'h0000, 1, 1, 1, 0, 16'h0000};
    tbl[4] = '{0, 0, 0, 12, 16'h0000, 1, 1, 1, 1, 16'h0000};
    tbl[5] = '{0, 0, 0,  0, 16'h0000, 0, 1, 1, 1, 16'h0000};
    tbl[6] = '{0, 0, 0,  0, 16'h0000, 0, 1, 1, 0, 16'h0000};
    for (int k = 0; k < NT; k++) exp1[k*CW +: CW] = CW'(k + 1);
    exp2 = exp1;
    exp2[2*CW +: CW] = 16'h8000;

    // Reset, then 200 idle clocks: strobes at clocks 40,80,...,200 only.
    do_cycle(1, 0, 0, 0, '0, 0);
    nst = 0;
    for (int i = 1; i <= 200; i++) begin
      do_cycle(0, 0, 0, 0, '0, 0);
      if (o_strobe) begin
        nst++;
        check("t1_strobe_pos", BW'(i), BW'(nst * DIV));
      end
    end
    check("t1_strobe_count", BW'(nst), BW'(5));
    check("t1_bus_zero", o_bus, '0);
    $display("t1 idle strobes=%0d", nst);

    // Table vectors starting from reset.
    for (int i = 0; i < 7; i++) begin
      do_cycle(tbl[i].r, tbl[i].f, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].rd);
      check("tbl_busy", BW'(o_busy), BW'(tbl[i].busy_e));
      check("tbl_addr_err", BW'(o_err), BW'(tbl[i].err_e));
      check("tbl_rd_valid", BW'(o_rdv), BW'(tbl[i].rdv_e));
      check("tbl_rd_dt", BW'(o_rd), BW'(tbl[i].rddt_e));
      $display("vec %0d rst=%0d flag=%0d we=%0d addr=%0d busy=%0d err=%0d rdv=%0d",
               i, tbl[i].r, tbl[i].f, tbl[i].w, tbl[i].a, o_busy, o_err, o_rdv);
    end

    // Session writing taps 1..10, flag dropped mid-sample; commit on the next strobe.
    do_cycle(1, 0, 0, 0, '0, 0);
    for (int i = 0; i < NT; i++) do_cycle(0, 1, 1, i, CW'(i + 1), 0);
    do_cycle(0, 0, 0, 0, '0, 0);
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      do_cycle(0, 0, 0, 0, '0, 0);
      if (o_commit) begin
        found = 1;
        check("t2_commit_on_strobe", BW'(o_strobe), BW'(1));
        check("t2_bus_old_at_commit", o_bus, '0);
        check("t2_commit_cycle", BW'(i), BW'(28));
      end
    end
    check("t2_commit_seen", BW'(found), BW'(1));
    do_cycle(0, 0, 0, 0, '0, 0);
    check("t2_bus_new", o_bus, exp1);
    $display("t2 session commit bus=%0h", o_bus);

    // Flag falls exactly on a strobe: no commit there, commit one sample later.
    for (int i = 0; i < DIV && (m_n % DIV) != DIV - 1; i++) do_cycle(0, 1, 0, 0, '0, 0);
    do_cycle(0, 0, 0, 0, '0, 0);
    check("t3_drop_on_strobe", BW'(o_strobe), BW'(1));
    check("t3_no_commit_at_drop", BW'(o_commit), BW'(0));
    pos = 0;
    cbase = n_commits;
    for (int i = 1; i <= 45; i++) begin
      do_cycle(0, 0, 0, 0, '0, 0);
      if (o_commit && pos == 0) pos = i;
    end
    check("t3_commit_delay", BW'(pos), BW'(DIV));
    check("t3_commit_count", BW'(n_commits - cbase), BW'(1));
    $display("t3 drop-on-strobe commit after %0d clocks", pos);

    // Reopen while pending, write tap 3 = 0x8000: exactly one commit.
    cbase = n_commits;
    do_cycle(0, 1, 0, 0, '0, 0);
    do_cycle(0, 1, 0, 0, '0, 0);
    do_cycle(0, 0, 0, 0, '0, 0);
    idle(3);
    do_cycle(0, 1, 1, 2, 16'h8000, 0);
    do_cycle(0, 0, 0, 0, '0, 0);
    idle(60);
    check("t4_commit_count", BW'(n_commits - cbase), BW'(1));
    check("t4_bus", o_bus, exp2);
    $display("t4 reopen commits=%0d bus=%0h", n_commits - cbase, o_bus);

    // Out-of-range write and read.
    do_cycle(0, 1, 1, 12, 16'hFFFF, 0);
    do_cycle(0, 1, 0, 12, '0, 1);
    check("t5_addr_err_set", BW'(o_err), BW'(1));
    do_cycle(0, 0, 0, 0, '0, 0);
    check("t5_rd_valid", BW'(o_rdv), BW'(1));
    check("t5_rd_zero", BW'(o_rd), BW'(0));
    idle(50);
    check("t5_addr_err_sticky", BW'(o_err), BW'(1));
    check("t5_bus_unchanged", o_bus, exp2);
    $display("t5 addr error err=%0d bus=%0h", o_err, o_bus);

    // Reset while pending: nothing committed, strobe counter restarts.
    cbase = n_commits;
    do_cycle(0, 1, 0, 0, '0, 0);
    do_cycle(0, 0, 0, 0, '0, 0);
    check("t6_pending_busy", BW'(o_busy), BW'(1));
    do_cycle(1, 0, 0, 0, '0, 0);
    check("t6_busy_in_reset", BW'(o_busy), BW'(0));
    pos = 0;
    for (int i = 1; i <= 60 && pos == 0; i++) begin
      do_cycle(0, 0, 0, 0, '0, 0);
      if (i == 1) begin
        check("t6_idle_after_reset", BW'(o_busy), BW'(0));
        check("t6_bus_cleared", o_bus, '0);
      end
      if (o_strobe) pos = i;
    end
    check("t6_first_strobe", BW'(pos), BW'(DIV));
    check("t6_no_commit", BW'(n_commits - cbase), BW'(0));
    $display("t6 reset in pending first strobe at %0d", pos);

    // Random traffic against the model.
    fl = 0;
    for (int blk = 0; blk < 6; blk++) begin
      cbase = n_commits;
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 7) == 0) fl = !fl;
        do_cycle($urandom_range(0, 599) == 0, fl, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 15)), CW'($urandom), $urandom_range(0, 2) == 0);
      end
      $display("random block %0d commits=%0d bus=%0h", blk, n_commits - cbase, o_bus);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
